// File: rtl/gpr_file_if.sv
// rtl/gpr_file_if.sv - writeback, decode-read, issue and flush signals of gpr_file
interface gpr_file_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              wena_i;
    logic [ADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [ADDR_W-1:0] raddr1_i;
    logic [ADDR_W-1:0] raddr2_i;
    logic [DATA_W-1:0] rdata1_o;
    logic [DATA_W-1:0] rdata2_o;
    logic              busy1_o;
    logic              busy2_o;
    logic              issue_valid_i;
    logic              issue_wena_i;
    logic [ADDR_W-1:0] issue_waddr_i;
    logic              issue_ready_o;
    logic              flush_i;
    logic              sb_err_o;

    modport slave (
        input  wena_i, waddr_i, wdata_i, raddr1_i, raddr2_i,
        input  issue_valid_i, issue_wena_i, issue_waddr_i, flush_i,
        output rdata1_o, rdata2_o, busy1_o, busy2_o, issue_ready_o, sb_err_o
    );

    modport master (
        output wena_i, waddr_i, wdata_i, raddr1_i, raddr2_i,
        output issue_valid_i, issue_wena_i, issue_waddr_i, flush_i,
        input  rdata1_o, rdata2_o, busy1_o, busy2_o, issue_ready_o, sb_err_o
    );
endinterface

// File: rtl/gpr_file.sv
// rtl/gpr_file.sv - bypassed two-read register file with per-register pending-write scoreboard
module gpr_file #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 2
) (
    input  logic      clock,
    input  logic      reset,
    gpr_file_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs    [REG_NUM];
    logic [CNT_W-1:0]  cnt     [REG_NUM];
    logic [CNT_W-1:0]  cnt_nxt [REG_NUM];
    logic              sb_err;
    logic              err_set;
    logic              retire;
    logic              issue;
    logic              retire_hits_issue;

    assign retire            = bus.wena_i && (bus.waddr_i != '0);
    assign retire_hits_issue = retire && (bus.waddr_i == bus.issue_waddr_i);

    // A retire to the same register frees the slot this issue would take.
    assign bus.issue_ready_o = !(bus.issue_wena_i && (cnt[bus.issue_waddr_i] == CNT_MAX)
                                 && !retire_hits_issue);
    assign issue = bus.issue_valid_i && bus.issue_wena_i
                   && (bus.issue_waddr_i != '0) && bus.issue_ready_o;

    always_comb begin
        bus.rdata1_o = '0;
        bus.rdata2_o = '0;
        if (reset) begin
            if (bus.raddr1_i != '0)
                bus.rdata1_o = (retire && bus.waddr_i == bus.raddr1_i) ? bus.wdata_i
                                                                       : regs[bus.raddr1_i];
            if (bus.raddr2_i != '0)
                bus.rdata2_o = (retire && bus.waddr_i == bus.raddr2_i) ? bus.wdata_i
                                                                       : regs[bus.raddr2_i];
        end
    end

    // Last outstanding write retiring now is covered by the bypass, so no stall.
    assign bus.busy1_o = (bus.raddr1_i != '0) && (cnt[bus.raddr1_i] != '0)
                         && !((cnt[bus.raddr1_i] == CNT_W'(1)) && retire
                              && (bus.waddr_i == bus.raddr1_i));
    assign bus.busy2_o = (bus.raddr2_i != '0) && (cnt[bus.raddr2_i] != '0)
                         && !((cnt[bus.raddr2_i] == CNT_W'(1)) && retire
                              && (bus.waddr_i == bus.raddr2_i));

    assign bus.sb_err_o = sb_err;

    always_comb begin
        for (int r = 0; r < REG_NUM; r++) begin
            cnt_nxt[r] = cnt[r];
            if (r == 0 || bus.flush_i) begin
                cnt_nxt[r] = '0;
            end else if (issue && bus.issue_waddr_i == ADDR_W'(r)
                         && !(retire && bus.waddr_i == ADDR_W'(r))) begin
                cnt_nxt[r] = cnt[r] + CNT_W'(1);
            end else if (retire && bus.waddr_i == ADDR_W'(r)
                         && !(issue && bus.issue_waddr_i == ADDR_W'(r))
                         && cnt[r] != '0) begin
                cnt_nxt[r] = cnt[r] - CNT_W'(1);
            end
        end
        err_set = retire && !(issue && retire_hits_issue) && (cnt[bus.waddr_i] == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (retire)
                regs[bus.waddr_i] <= bus.wdata_i;
            for (int r = 0; r < REG_NUM; r++)
                cnt[r] <= cnt_nxt[r];
            if (err_set)
                sb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_gpr_file.sv
// tb/tb_gpr_file.sv - directed stimulus with queued expectations checked by a negedge monitor
module tb_gpr_file;
    localparam int K_RD1 = 0, K_RD2 = 1, K_BUSY1 = 2, K_BUSY2 = 3, K_READY = 4, K_ERR = 5;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic clock;
    logic reset;
    exp_t q[$];
    int   pass_cnt;
    int   total_cnt;

    gpr_file_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    gpr_file #(.REG_NUM(32), .ADDR_W(5), .DATA_W(32), .CNT_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] sample(input int kind);
        case (kind)
            K_RD1:   return bus.rdata1_o;
            K_RD2:   return bus.rdata2_o;
            K_BUSY1: return {31'b0, bus.busy1_o};
            K_BUSY2: return {31'b0, bus.busy2_o};
            K_READY: return {31'b0, bus.issue_ready_o};
            default: return {31'b0, bus.sb_err_o};
        endcase
    endfunction

    always @(negedge clock) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = q.pop_front();
            act = sample(e.kind);
            total_cnt++;
            if (act === e.exp) pass_cnt++;
            else $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
        end
    end

    task automatic expect_val(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic idle();
        bus.wena_i        = 1'b0;
        bus.waddr_i       = '0;
        bus.wdata_i       = '0;
        bus.raddr1_i      = '0;
        bus.raddr2_i      = '0;
        bus.issue_valid_i = 1'b0;
        bus.issue_wena_i  = 1'b0;
        bus.issue_waddr_i = '0;
        bus.flush_i       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_issue(input logic [4:0] a);
        bus.issue_valid_i = 1'b1;
        bus.issue_wena_i  = 1'b1;
        bus.issue_waddr_i = a;
    endtask

    task automatic do_retire(input logic [4:0] a, input logic [31:0] d);
        bus.wena_i  = 1'b1;
        bus.waddr_i = a;
        bus.wdata_i = d;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b0;
        idle();
        // activity during reset must not leak onto the outputs
        do_retire(5'd5, 32'hFFFF_FFFF);
        bus.raddr1_i = 5'd5;
        expect_val(K_RD1, 32'h0, "reset_rd1_bypass_gated");
        expect_val(K_BUSY1, 32'h0, "reset_busy1");
        expect_val(K_READY, 32'h1, "reset_ready");
        expect_val(K_ERR, 32'h0, "reset_err");
        tick();
        idle();
        reset = 1'b1;

        for (int i = 1; i < 32; i++) begin
            bus.raddr1_i = 5'(i);
            bus.raddr2_i = 5'(i);
            expect_val(K_RD1, 32'h0, "post_reset_rd1");
            expect_val(K_RD2, 32'h0, "post_reset_rd2");
            expect_val(K_BUSY1, 32'h0, "post_reset_busy1");
            expect_val(K_BUSY2, 32'h0, "post_reset_busy2");
            tick();
        end
        idle();

        // x5 write: bypass in the retire cycle, array next cycle
        do_issue(5'd5);
        expect_val(K_READY, 32'h1, "x5_issue_ready");
        tick();
        idle();
        do_retire(5'd5, 32'hDEAD_BEEF);
        bus.raddr1_i = 5'd5;
        expect_val(K_RD1, 32'hDEAD_BEEF, "x5_bypass");
        expect_val(K_BUSY1, 32'h0, "x5_busy_bypass");
        tick();
        idle();
        bus.raddr1_i = 5'd5;
        expect_val(K_RD1, 32'hDEAD_BEEF, "x5_array");
        expect_val(K_ERR, 32'h0, "x5_no_err");
        tick();
        idle();
        do_retire(5'd0, 32'h1234);
        bus.raddr2_i = 5'd0;
        expect_val(K_RD2, 32'h0, "x0_write_bypass");
        tick();
        idle();
        expect_val(K_RD1, 32'h0, "x0_array");
        expect_val(K_ERR, 32'h0, "x0_no_err");
        tick();

        // x7: fill to max, then retire concurrent with a blocked issue
        bus.raddr1_i = 5'd7;
        for (int i = 0; i < 3; i++) begin
            do_issue(5'd7);
            expect_val(K_READY, 32'h1, "x7_issue_ready");
            expect_val(K_BUSY1, (i == 0) ? 32'h0 : 32'h1, "x7_busy_fill");
            tick();
        end
        expect_val(K_READY, 32'h0, "x7_full_not_ready");
        expect_val(K_BUSY1, 32'h1, "x7_busy_full");
        tick();
        do_retire(5'd7, 32'h77);
        expect_val(K_READY, 32'h1, "x7_retire_frees_ready");
        expect_val(K_BUSY1, 32'h1, "x7_busy_cnt3");
        expect_val(K_RD1, 32'h77, "x7_bypass");
        tick();
        bus.wena_i = 1'b0;
        expect_val(K_READY, 32'h0, "x7_cnt_stays_3");
        tick();
        idle();
        bus.raddr1_i = 5'd7;
        for (int i = 0; i < 3; i++) begin
            do_retire(5'd7, 32'(8'h70 + i));
            expect_val(K_BUSY1, (i == 2) ? 32'h0 : 32'h1, "x7_drain_busy");
            tick();
        end
        idle();
        bus.raddr1_i = 5'd7;
        expect_val(K_BUSY1, 32'h0, "x7_drained");
        expect_val(K_RD1, 32'h72, "x7_last_data");
        expect_val(K_ERR, 32'h0, "x7_no_err");
        tick();

        // x9: single pending write retired while being read
        idle();
        do_issue(5'd9);
        bus.raddr1_i = 5'd9;
        expect_val(K_BUSY1, 32'h0, "x9_busy_issue_cycle");
        tick();
        idle();
        bus.raddr1_i = 5'd9;
        bus.raddr2_i = 5'd9;
        expect_val(K_BUSY1, 32'h1, "x9_busy1_pending");
        expect_val(K_BUSY2, 32'h1, "x9_busy2_pending");
        tick();
        do_retire(5'd9, 32'h55);
        expect_val(K_BUSY1, 32'h0, "x9_busy1_retire");
        expect_val(K_BUSY2, 32'h0, "x9_busy2_retire");
        expect_val(K_RD1, 32'h55, "x9_rd1_bypass");
        expect_val(K_RD2, 32'h55, "x9_rd2_bypass");
        tick();
        bus.wena_i = 1'b0;
        expect_val(K_BUSY1, 32'h0, "x9_cnt_zero");
        expect_val(K_RD1, 32'h55, "x9_array");
        tick();

        // flush with concurrent retire and issue
        idle();
        do_issue(5'd3);
        tick();
        do_issue(5'd4);
        tick();
        idle();
        bus.raddr1_i = 5'd3;
        bus.raddr2_i = 5'd4;
        expect_val(K_BUSY1, 32'h1, "flush_pre_busy3");
        expect_val(K_BUSY2, 32'h1, "flush_pre_busy4");
        tick();
        bus.flush_i = 1'b1;
        do_retire(5'd3, 32'hAA);
        do_issue(5'd4);
        expect_val(K_RD1, 32'hAA, "flush_x3_bypass");
        expect_val(K_BUSY2, 32'h1, "flush_busy4_same_cycle");
        tick();
        idle();
        bus.raddr1_i = 5'd3;
        bus.raddr2_i = 5'd4;
        expect_val(K_BUSY1, 32'h0, "flush_busy3_cleared");
        expect_val(K_BUSY2, 32'h0, "flush_busy4_cleared");
        expect_val(K_RD1, 32'hAA, "flush_x3_written");
        expect_val(K_ERR, 32'h0, "flush_no_err");
        tick();

        // retire with zero pending sets the sticky error
        idle();
        do_retire(5'd12, 32'hC);
        bus.raddr1_i = 5'd12;
        expect_val(K_ERR, 32'h0, "x12_err_not_yet");
        expect_val(K_BUSY1, 32'h0, "x12_busy_retire");
        tick();
        idle();
        bus.raddr1_i = 5'd12;
        expect_val(K_ERR, 32'h1, "x12_err_set");
        expect_val(K_BUSY1, 32'h0, "x12_cnt_zero");
        expect_val(K_RD1, 32'hC, "x12_data");
        tick();
        expect_val(K_ERR, 32'h1, "x12_err_sticky");
        tick();

        // async reset mid-run clears error and array
        bus.raddr1_i = 5'd5;
        reset = 1'b0;
        #1;
        expect_val(K_ERR, 32'h0, "reset2_err");
        expect_val(K_RD1, 32'h0, "reset2_rd1");
        tick();
        reset = 1'b1;
        expect_val(K_RD1, 32'h0, "reset2_x5_cleared");
        expect_val(K_ERR, 32'h0, "reset2_err_after");
        tick();

        @(negedge clock);
        #1;
        if (q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
